// File: rtl/switch_pkg.sv
// Shared constants for the slide-switch conditioning path.
// Also holds the helper that sizes the debounce counter.
package switch_pkg;

    localparam int SW_WIDTH            = 8;
    localparam int DEBOUNCE_10MS_50MHZ = 500000;
    localparam int SIM_DEBOUNCE_CYCLES = 4;

    // Counter must hold values up to cycles-1; sized with one value of headroom.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-FF synchroniser, stability counter, clean level and
// registered rise/fall pulses. edge_next exposes the pulse about to be registered.
module switch_debounce_bit
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE_CYCLES,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic edge_next
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_d;
    logic             rise_d;
    logic             fall_d;

    // Any cycle where sync2 agrees with clean discards the partial count.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2 != clean) begin
            if (cnt == CNT_LAST) begin
                clean_d = sync2;
                rise_d  = sync2;
                fall_d  = ~sync2;
            end else begin
                cnt_d = cnt + 1'b1;
            end
        end
    end

    assign edge_next = rise_d | fall_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            cnt   <= cnt_d;
            clean <= clean_d;
            rise  <= rise_d;
            fall  <= fall_d;
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the slide-switch bus for the PIO in_port and produces
// per-bit edge pulses plus a bus-wide change pulse.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 2**24) begin : g_bad_cycles
        $error("switch_debouncer: DEBOUNCE_CYCLES out of range");
    end

    logic [WIDTH-1:0] edge_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk       (clk),
            .reset_n   (reset_n),
            .raw       (sw_raw[i]),
            .clean     (sw_clean[i]),
            .rise      (sw_rise[i]),
            .fall      (sw_fall[i]),
            .edge_next (edge_next[i])
        );
    end

    // Built from the per-bit next-state pulses so it lands in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sw_changed <= 1'b0;
        else          sw_changed <= |edge_next;
    end

endmodule
